// File: rtl/mailbox_wr_arbiter.sv
// mailbox_wr_arbiter: round-robin arbiter sharing one mailbox FIFO write port
// among N_NUMB_CPU requesters, with a registered packed output entry.
// Ports: clk, rst_n (sync, active-low); req_i/data_i/addr_i per-CPU request
// slices; grant_o one-hot grant; fifo_wr_o/fifo_wdata_o/fifo_full_i FIFO side.
// Optional: define MAILBOX_ARB_SEQ_EN for per-source 8-bit sequence counters
// carried in header[15:8]; otherwise that field reads 0.

package mailbox_pkg;
    localparam int N_NUMB_CPU  = 4;
    localparam int W_WIDTH_SYS = 32;
    localparam int WIDTH_ADDR  = 32;
endpackage

module mailbox_wr_arbiter #(
    parameter int N_NUMB_CPU  = mailbox_pkg::N_NUMB_CPU,
    parameter int W_WIDTH_SYS = mailbox_pkg::W_WIDTH_SYS,
    parameter int WIDTH_ADDR  = mailbox_pkg::WIDTH_ADDR,
    parameter int FIFO_DATA   = W_WIDTH_SYS + WIDTH_ADDR + 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_NUMB_CPU-1:0]             req_i,
    input  logic [N_NUMB_CPU*W_WIDTH_SYS-1:0] data_i,
    input  logic [N_NUMB_CPU*WIDTH_ADDR-1:0]  addr_i,
    output logic [N_NUMB_CPU-1:0]             grant_o,
    output logic                              fifo_wr_o,
    output logic [FIFO_DATA-1:0]              fifo_wdata_o,
    input  logic                              fifo_full_i
);

    localparam int RRW = (N_NUMB_CPU > 2) ? $clog2(N_NUMB_CPU) : 1;

    logic                   valid_q;
    logic [FIFO_DATA-1:0]   entry_q;
    logic [RRW-1:0]         rr_q;

    logic                   ld;
    logic                   found;
    logic [RRW-1:0]         win;
    logic [RRW-1:0]         cand;
    logic [RRW-1:0]         rr_d;
    logic [7:0]             seq_w;
    logic [31:0]            hdr;
    int                     idx;
    int                     nxt;

    logic [W_WIDTH_SYS-1:0] data_a [N_NUMB_CPU];
    logic [WIDTH_ADDR-1:0]  addr_a [N_NUMB_CPU];

    for (genvar i = 0; i < N_NUMB_CPU; i++) begin : g_unpack
        assign data_a[i] = data_i[i*W_WIDTH_SYS +: W_WIDTH_SYS];
        assign addr_a[i] = addr_i[i*WIDTH_ADDR +: WIDTH_ADDR];
    end

    // The output register may load whenever it is empty or draining.
    assign ld = !valid_q || !fifo_full_i;

    // Walk from the lowest priority slot up to rr so the last hit wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = N_NUMB_CPU - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= N_NUMB_CPU) begin
                idx = idx - N_NUMB_CPU;
            end
            cand = RRW'(idx);
            if (req_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        nxt = int'(win) + 1;
        if (nxt == N_NUMB_CPU) begin
            nxt = 0;
        end
        rr_d = RRW'(nxt);
    end

    always_comb begin
        grant_o = '0;
        if (rst_n && ld && found) begin
            grant_o[win] = 1'b1;
        end
    end

`ifdef MAILBOX_ARB_SEQ_EN
    logic [7:0] seq_q [N_NUMB_CPU];

    assign seq_w = seq_q[win];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NUMB_CPU; i++) begin
                seq_q[i] <= 8'h00;
            end
        end else if (ld && found) begin
            seq_q[win] <= seq_q[win] + 8'd1;
        end
    end
`else
    assign seq_w = 8'h00;
`endif

    assign hdr = {16'h0000, seq_w, 8'(win)};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            entry_q <= '0;
            rr_q    <= '0;
        end else if (ld) begin
            if (found) begin
                valid_q <= 1'b1;
                entry_q <= {hdr, addr_a[win], data_a[win]};
                rr_q    <= rr_d;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign fifo_wr_o    = valid_q;
    assign fifo_wdata_o = entry_q;

endmodule

// File: tb/tb_mailbox_wr_arbiter.sv
// tb_mailbox_wr_arbiter: directed bench with a behavioural reference model
// compared every cycle, plus literal expectations for key scenarios.

module tb_mailbox_wr_arbiter;

    localparam int N  = 4;
    localparam int FD = 96;

`ifdef MAILBOX_ARB_SEQ_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_i = '0;
    logic          fifo_full_i = 1'b0;
    logic [31:0]   d_arr [N];
    logic [31:0]   a_arr [N];
    logic [N*32-1:0] data_i;
    logic [N*32-1:0] addr_i;
    logic [N-1:0]  grant_o;
    logic          fifo_wr_o;
    logic [FD-1:0] fifo_wdata_o;

    int n_checks = 0;
    int n_fail = 0;

    assign data_i = {d_arr[3], d_arr[2], d_arr[1], d_arr[0]};
    assign addr_i = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};

    always #5 clk = ~clk;

    mailbox_wr_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .data_i       (data_i),
        .addr_i       (addr_i),
        .grant_o      (grant_o),
        .fifo_wr_o    (fifo_wr_o),
        .fifo_wdata_o (fifo_wdata_o),
        .fifo_full_i  (fifo_full_i)
    );

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int sq(input int v);
        return SEQ ? v : 0;
    endfunction

    // Reference model: queue-free abstract state of the arbiter.
    bit          m_known = 1'b0;
    bit          m_valid;
    logic [95:0] m_entry;
    int          m_rr;
    int          m_seq [N];

    function automatic int m_winner();
        for (int k = 0; k < N; k++) begin
            if (req_i[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [95:0] m_pack(input int g);
        logic [7:0] s;
        logic [7:0] src;
        s   = 8'(sq(m_seq[g]));
        src = 8'(g);
        return {16'h0000, s, src, a_arr[g], d_arr[g]};
    endfunction

    always @(posedge clk) begin
        int g;
        if (!rst_n) begin
            m_known = 1'b1;
            m_valid = 1'b0;
            m_entry = '0;
            m_rr = 0;
            for (int i = 0; i < N; i++) m_seq[i] = 0;
        end else if (m_known && (!m_valid || !fifo_full_i)) begin
            g = m_winner();
            if (g >= 0) begin
                m_entry  = m_pack(g);
                m_valid  = 1'b1;
                m_seq[g] = (m_seq[g] + 1) % 256;
                m_rr     = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] eg;
        int g;
        if (m_known) begin
            eg = '0;
            if (rst_n && (!m_valid || !fifo_full_i)) begin
                g = m_winner();
                if (g >= 0) eg[g] = 1'b1;
            end
            chk("model_grant", grant_o, eg);
            chk("model_wr", fifo_wr_o, m_valid);
            chk("model_wdata", fifo_wdata_o, m_entry);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] eg;
        logic [95:0]  ee;
        for (int i = 0; i < N; i++) begin
            d_arr[i] = 32'h1000_0000 + i;
            a_arr[i] = 32'h0000_0200 + i;
        end
        rst_n = 1'b0;
        req_i = 4'hF;
        @(negedge clk);
        chk("rst_grant", grant_o, 4'b0000);
        tick();
        @(negedge clk);
        chk("rst_wr", fifo_wr_o, 1'b0);
        chk("rst_wdata", fifo_wdata_o, 96'h0);

        // Single CPU2 request.
        tick();
        rst_n = 1'b1;
        req_i = 4'b0100;
        d_arr[2] = 32'hA5A5_0001;
        a_arr[2] = 32'h0000_0100;
        @(negedge clk);
        chk("t1_grant", grant_o, 4'b0100);
        tick();
        req_i = 4'b0000;
        @(negedge clk);
        chk("t1_wr", fifo_wr_o, 1'b1);
        chk("t1_wdata", fifo_wdata_o,
            96'h0000_0002_0000_0100_A5A5_0001);
        tick();
        req_i = 4'b1001;
        @(negedge clk);
        chk("t1_rr", grant_o, 4'b1000);
        tick();
        req_i = 4'b0000;
        d_arr[2] = 32'h1000_0002;
        a_arr[2] = 32'h0000_0202;
        tick();

        // All four requesting back to back.
        do_reset();
        req_i = 4'hF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            eg = '0;
            eg[c % N] = 1'b1;
            chk("rr_grant", grant_o, eg);
            if (c > 0) begin
                chk("rr_wr", fifo_wr_o, 1'b1);
                chk("rr_src", fifo_wdata_o[71:64], 8'((c - 1) % N));
                chk("rr_seq", fifo_wdata_o[87:80],
                    8'(sq(c == 5 ? 1 : 0)));
            end
            tick();
        end

        // Backpressure with CPU1 waiting.
        fifo_full_i = 1'b1;
        req_i = 4'b0010;
        ee = {16'h0000, 8'(sq(1)), 8'h01, 32'h0000_0201, 32'h1000_0001};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("full_grant", grant_o, 4'b0000);
            chk("full_wr", fifo_wr_o, 1'b1);
            chk("full_hold", fifo_wdata_o, ee);
            tick();
        end
        fifo_full_i = 1'b0;
        @(negedge clk);
        chk("full_drop_grant", grant_o, 4'b0010);
        tick();
        req_i = 4'b0000;
        @(negedge clk);
        chk("full_drop_src", fifo_wdata_o[71:64], 8'h01);
        chk("full_drop_seq", fifo_wdata_o[87:80], 8'(sq(2)));
        tick();

        // Sequence wrap on CPU0.
        do_reset();
        req_i = 4'b0001;
        for (int n = 0; n < 258; n++) begin
            @(negedge clk);
            chk("wrap_grant", grant_o, 4'b0001);
            if (n > 0) begin
                chk("wrap_seq", fifo_wdata_o[87:80], 8'(sq((n - 1) % 256)));
            end
            tick();
        end

        // Reset while an entry is held under full.
        fifo_full_i = 1'b1;
        req_i = 4'b0000;
        @(negedge clk);
        chk("hold_wr", fifo_wr_o, 1'b1);
        tick();
        rst_n = 1'b0;
        req_i = 4'b1010;
        @(negedge clk);
        chk("rst_hold_grant", grant_o, 4'b0000);
        tick();
        rst_n = 1'b1;
        fifo_full_i = 1'b0;
        @(negedge clk);
        chk("rst_hold_wr", fifo_wr_o, 1'b0);
        chk("rst_hold_wdata", fifo_wdata_o, 96'h0);
        chk("rst_first_grant", grant_o, 4'b0010);
        tick();
        req_i = 4'b0000;
        @(negedge clk);
        chk("rst_first_entry", fifo_wdata_o,
            96'h0000_0001_0000_0201_1000_0001);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mailbox_wr_arbiter.md
# mailbox_wr_arbiter

Round-robin write arbiter that shares the single mailbox FIFO write port among `N_NUMB_CPU` CPU requesters. It captures one request per cycle into a registered output stage, packs it with a 32-bit header into a `FIFO_DATA`-bit entry, and drives the FIFO write port with full-backpressure. It sits between the CPU-side mailbox write interfaces and the shared `K_FIFO_DEPTH` mailbox FIFO. Widths come from `mailbox_pkg`.

## Interface
- `N_NUMB_CPU`, 4, number of requesters; must be 2..256.
- `W_WIDTH_SYS`, 32, data width per request.
- `WIDTH_ADDR`, 32, address width per request.
- `FIFO_DATA`, `W_WIDTH_SYS+WIDTH_ADDR+32`, width of the packed FIFO entry.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_i`  in  N_NUMB_CPU  per-CPU write request; held with its data until granted.
- `data_i`  in  N_NUMB_CPU*W_WIDTH_SYS  per-CPU payload; CPU i occupies slice i.
- `addr_i`  in  N_NUMB_CPU*WIDTH_ADDR  per-CPU destination address; CPU i occupies slice i.
- `grant_o`  out  N_NUMB_CPU  one-hot (or zero) combinational grant; request captured at this edge.
- `fifo_wr_o`  out  1  entry valid toward FIFO.
- `fifo_wdata_o`  out  FIFO_DATA  packed entry.
- `fifo_full_i`  in  1  FIFO full; the write is accepted only when low.

## Operation
- Output stage is a single register (`valid`, `entry`). `fifo_wr_o` = `valid`.
- Accept: `fifo_wr_o && !fifo_full_i` at a rising edge.
- Load enable `ld = !valid || !fifo_full_i`. When `ld` is high and any `req_i` is set, exactly one grant is issued. The winner's data, address and header load into the output register, and `valid` becomes 1.
- When `ld` is high and there is no request, `valid` becomes 0 after an accept.
- When `ld` is low (valid and full), `grant_o` is 0 and the register holds.
- Round-robin: pointer `rr` (log2 N bits) is the highest-priority index. Search `rr, rr+1, …` with modulo-N wrap. After a grant to index g, `rr = (g+1) mod N`.
- Entry packing, MSB first: `{header[31:0], addr, data}`.
  - `header[7:0]` = source CPU index.
  - `header[15:8]` = per-source sequence number; see Configuration.
  - `header[31:16]` = 0.
- Sequence counters: one 8-bit counter per source. It increments on that source's grant and wraps 255→0. The value placed in the header is the pre-increment value.

## Timing
- Reset (rst_n low at edge):
  - `valid`, `fifo_wdata_o`, `rr` and all sequence counters clear to 0.
  - `grant_o` is forced 0 while `rst_n` is low.
  - A pending entry is discarded.
  - First grant after reset favours CPU0.
- Latency: request granted in cycle t → `fifo_wr_o` high in cycle t+1.
- Throughput is one entry per cycle while `fifo_full_i` stays low. Accept and new load in the same cycle give back-to-back writes with no bubble.
- While `fifo_full_i` is high and `valid` is 1:
  - Entry and `fifo_wr_o` are held stable.
  - No grants; requesters wait.
- `fifo_full_i` falling at cycle t: the held entry is accepted at the end of t, and a new grant in t loads simultaneously.
- A request withdrawn before grant is legal and has no effect. Data must be stable in the grant cycle.
- Fairness: any continuously asserted request is granted within N grant cycles.

## Configuration
- `MAILBOX_ARB_SEQ_EN` defined: per-source 8-bit sequence counters are implemented, and `header[15:8]` carries the count.
- Undefined: no counters are synthesized and `header[15:8]` = 0. All other behaviour is identical.

## Test plan
- Reset, then CPU2 alone requests data=0xA5A5_0001, addr=0x100 → `grant_o`=0100 in that cycle. Next cycle `fifo_wr_o`=1 and `fifo_wdata_o`={0x0000_0002, 0x100, 0xA5A5_0001}. Next `rr`=3.
- All 4 CPUs request continuously, full low → grants 0,1,2,3,0 on consecutive cycles. `fifo_wr_o` stays high from the second cycle on. With the macro on, the sequence fields read 0,0,0,0,1.
- Hold `fifo_full_i`=1 for 5 cycles with an entry valid and CPU1 requesting → entry stable and `grant_o`=0 throughout. Full drops → entry accepted and CPU1 granted in the same cycle.
- CPU0 granted 257 times with the macro on → sequence fields read 0..255, then 0. With the macro off, the field is always 0.
- Assert `rst_n`=0 while an entry is held under full → next cycle `fifo_wr_o`=0, `fifo_wdata_o`=0, sequence counters 0, and the first grant after release goes to the lowest requesting index starting from CPU0.
